// File: rtl/la_check_pkg.sv
// Shared types and constants for the logic-analyzer checkpoint monitor.
package la_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_SKIP    = 2'd2;

  localparam logic [15:0] CKPT_START = 16'hAB40;
  localparam logic [15:0] CKPT_MID   = 16'hAB41;
  localparam logic [15:0] CKPT_DONE  = 16'hAB51;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/la_checkpoint_filter.sv
// Pad-field synchroniser and stability filter: strobes qual once per value
// that stays constant for STABLE_CYCLES synchronised samples.
module la_checkpoint_filter #(
  parameter int WIDTH         = 16,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             qual,
  output logic [WIDTH-1:0] stable_val
);

  localparam int              CNTW    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(STABLE_CYCLES);

  logic [WIDTH-1:0] meta_q, sync_q, prev_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             qual_q, qual_d;

  always_comb begin
    cnt_d    = cnt_q;
    qual_d   = 1'b0;
    stable_d = stable_q;
    if (clear || (sync_q != prev_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNTW'(1);
    end
    // Fires only on the transition into saturation, so a held value strobes once.
    qual_d = (cnt_q != CNT_MAX) && (cnt_d == CNT_MAX);
    if (qual_d) stable_d = sync_q;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      meta_q   <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      qual_q   <= 1'b0;
      stable_q <= '0;
    end else begin
      meta_q   <= din;
      sync_q   <= meta_q;
      prev_q   <= sync_q;
      cnt_q    <= cnt_d;
      qual_q   <= qual_d;
      stable_q <= stable_d;
    end
  end

  assign qual       = qual_q;
  assign stable_val = stable_q;

endmodule

// File: rtl/la_checkpoint_monitor.sv
// Matches qualified checkpoint codes against an ordered expected list and
// reports pass / fail (timeout or skip) with progress and elapsed cycles.
module la_checkpoint_monitor
  import la_check_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int NUM_CKPT       = 3,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int IDXW           = $clog2(NUM_CKPT + 1)
) (
  input  logic                      clock,
  input  logic                      resetb,
  input  logic                      start,
  input  logic                      strict,
  input  logic [WIDTH-1:0]          checkbits,
  input  logic [NUM_CKPT*WIDTH-1:0] exp_codes,
  output logic                      busy,
  output logic                      pass,
  output logic                      fail,
  output logic [1:0]                fail_code,
  output logic [IDXW-1:0]           ckpt_idx,
  output logic                      ckpt_hit,
  output logic [WIDTH-1:0]          stable_val,
  output logic [31:0]               elapsed
);

  logic             qual;
  logic [WIDTH-1:0] qual_val;

  la_checkpoint_filter #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clock      (clock),
    .resetb     (resetb),
    .clear      (start),
    .din        (checkbits),
    .qual       (qual),
    .stable_val (qual_val)
  );

  state_e                           state_q, state_d;
  logic [NUM_CKPT-1:0][WIDTH-1:0]   exp_q, exp_d;
  logic                             strict_q, strict_d;
  logic [IDXW-1:0]                  idx_q, idx_d;
  logic [31:0]                      elapsed_q, elapsed_d;
  logic                             hit_q, hit_d;
  logic [1:0]                       fc_q, fc_d;
  logic                             cur_match, later_match, last_ckpt, timeout;

  // Compare the qualified value against the current slot and every later slot.
  always_comb begin
    cur_match   = 1'b0;
    later_match = 1'b0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      if ((IDXW'(i) == idx_q) && (exp_q[i] == qual_val)) cur_match   = 1'b1;
      if ((IDXW'(i) >  idx_q) && (exp_q[i] == qual_val)) later_match = 1'b1;
    end
    last_ckpt = (idx_q == IDXW'(NUM_CKPT - 1));
    timeout   = (elapsed_q == 32'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    strict_d  = strict_q;
    idx_d     = idx_q;
    elapsed_d = elapsed_q;
    hit_d     = 1'b0;
    fc_d      = fc_q;
    if (start) begin
      // Re-arm from any state; a qual landing this cycle is dropped.
      state_d   = ARMED;
      exp_d     = exp_codes;
      strict_d  = strict;
      idx_d     = '0;
      elapsed_d = '0;
      fc_d      = FC_NONE;
    end else begin
      case (state_q)
        ARMED: begin
          elapsed_d = sat_inc32(elapsed_q);
          if (qual && cur_match) begin
            hit_d = 1'b1;
            idx_d = idx_q + IDXW'(1);
            if (last_ckpt) state_d = PASS;
          end else if (qual && strict_q && later_match) begin
            state_d = FAIL;
            fc_d    = FC_SKIP;
          end
          // A final hit on the timeout cycle has already moved us to PASS.
          if (timeout && (state_d == ARMED)) begin
            state_d = FAIL;
            fc_d    = FC_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= IDLE;
      exp_q     <= '0;
      strict_q  <= 1'b0;
      idx_q     <= '0;
      elapsed_q <= '0;
      hit_q     <= 1'b0;
      fc_q      <= FC_NONE;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      strict_q  <= strict_d;
      idx_q     <= idx_d;
      elapsed_q <= elapsed_d;
      hit_q     <= hit_d;
      fc_q      <= fc_d;
    end
  end

  assign busy       = (state_q == ARMED);
  assign pass       = (state_q == PASS);
  assign fail       = (state_q == FAIL);
  assign fail_code  = fc_q;
  assign ckpt_idx   = idx_q;
  assign ckpt_hit   = hit_q;
  assign stable_val = qual_val;
  assign elapsed    = elapsed_q;

endmodule

// File: tb/tb_la_checkpoint_monitor.sv
// Bench for la_checkpoint_monitor: directed vector table, hand sequences and
// randomized pad traffic against an edge-indexed reference model.
module tb_la_checkpoint_monitor;
  import la_check_pkg::*;

  localparam int W  = 16;
  localparam int N  = 3;
  localparam int S  = 4;
  localparam int TO = 100;
  localparam int IW = $clog2(N + 1);

  logic           clock = 1'b0;
  logic           resetb = 1'b0;
  logic           start = 1'b0;
  logic           strict = 1'b0;
  logic [W-1:0]   checkbits = '0;
  logic [N*W-1:0] exp_codes = '0;
  logic           busy, pass, fail, ckpt_hit;
  logic [1:0]     fail_code;
  logic [IW-1:0]  ckpt_idx;
  logic [W-1:0]   stable_val;
  logic [31:0]    elapsed;

  la_checkpoint_monitor #(
    .WIDTH(W), .NUM_CKPT(N), .STABLE_CYCLES(S), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .resetb(resetb), .start(start), .strict(strict),
    .checkbits(checkbits), .exp_codes(exp_codes), .busy(busy), .pass(pass),
    .fail(fail), .fail_code(fail_code), .ckpt_idx(ckpt_idx),
    .ckpt_hit(ckpt_hit), .stable_val(stable_val), .elapsed(elapsed)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pad samples indexed by edge number since reset release.
  logic [15:0]    pads[$];
  int             m_lastclr;
  bit             m_qual;
  logic [15:0]    m_sv;
  bit             m_armed, m_passed, m_failed, m_hit, m_strict;
  logic [1:0]     m_fc;
  int             m_idx;
  logic [31:0]    m_el;
  logic [N*W-1:0] m_exp;

  function automatic logic [15:0] padv(input int i);
    return (i < 0) ? 16'h0 : pads[i];
  endfunction

  function automatic logic [15:0] code(input int i);
    return m_exp[i*W +: W];
  endfunction

  task automatic m_reset();
    pads.delete();
    m_lastclr = -1; m_qual = 0; m_sv = '0;
    m_armed = 0; m_passed = 0; m_failed = 0; m_hit = 0; m_strict = 0;
    m_fc = 2'd0; m_idx = 0; m_el = '0; m_exp = '0;
  endtask

  task automatic model_edge();
    int n;
    bit ended;
    bit later;
    logic [31:0] old_el;
    if (!resetb) begin
      m_reset();
      return;
    end
    pads.push_back(checkbits);
    n = pads.size() - 1;
    m_hit = 0;
    if (start) begin
      m_armed = 1; m_passed = 0; m_failed = 0; m_fc = 2'd0;
      m_idx = 0; m_el = '0; m_exp = exp_codes; m_strict = strict;
    end else if (m_armed) begin
      ended  = 0;
      old_el = m_el;
      if (m_el != 32'hFFFF_FFFF) m_el = m_el + 1;
      later = 0;
      for (int j = m_idx + 1; j < N; j++) if (code(j) == m_sv) later = 1;
      if (m_qual && code(m_idx) == m_sv) begin
        m_hit = 1;
        m_idx++;
        if (m_idx == N) begin m_armed = 0; m_passed = 1; ended = 1; end
      end else if (m_qual && m_strict && later) begin
        m_armed = 0; m_failed = 1; m_fc = 2'd2; ended = 1;
      end
      if (!ended && old_el == 32'(TO - 1)) begin
        m_armed = 0; m_failed = 1; m_fc = 2'd1;
      end
    end
    // Qualification: S unchanged synchronised samples since last change or start.
    if (start || padv(n - 2) != padv(n - 3)) m_lastclr = n;
    m_qual = ((n - m_lastclr) == S);
    if (m_qual) m_sv = padv(n - 2);
  endtask

  task automatic check_all();
    chk("busy", busy, m_armed);
    chk("pass", pass, m_passed);
    chk("fail", fail, m_failed);
    chk("fail_code", fail_code, m_fc);
    chk("ckpt_idx", ckpt_idx, m_idx);
    chk("ckpt_hit", ckpt_hit, m_hit);
    chk("stable_val", stable_val, m_sv);
    chk("elapsed", elapsed, m_el);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic n_tick(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic arm(input bit s);
    strict = s;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  typedef struct {
    logic [15:0] pad;
    int          hold;
    int          e_idx;
    int          e_lat;   // edges from first sampling edge to hit, -1 = none
    bit          e_busy;
    bit          e_pass;
    bit          e_fail;
    int          e_fc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [15:0] p, input int h, input int i,
                              input int l, input bit b, input bit ps,
                              input bit f, input int fc);
    vec_t v;
    v.pad = p; v.hold = h; v.e_idx = i; v.e_lat = l;
    v.e_busy = b; v.e_pass = ps; v.e_fail = f; v.e_fc = fc;
    return v;
  endfunction

  task automatic run_rows(input int first, input int last);
    int hit_at;
    for (int r = first; r <= last; r++) begin
      checkbits = tbl[r].pad;
      hit_at = -1;
      for (int k = 1; k <= tbl[r].hold; k++) begin
        tick();
        if (ckpt_hit && hit_at < 0) hit_at = k - 1;
      end
      chk($sformatf("row%0d_lat", r), hit_at, tbl[r].e_lat);
      chk($sformatf("row%0d_idx", r), ckpt_idx, tbl[r].e_idx);
      chk($sformatf("row%0d_busy", r), busy, tbl[r].e_busy);
      chk($sformatf("row%0d_pass", r), pass, tbl[r].e_pass);
      chk($sformatf("row%0d_fail", r), fail, tbl[r].e_fail);
      chk($sformatf("row%0d_fc", r), fail_code, tbl[r].e_fc);
    end
  endtask

  task automatic prep();
    checkbits = '0;
    n_tick(10);
  endtask

  initial begin
    int hit_at;
    int hold_left;
    int rst_left;
    logic [15:0] pool [0:3];
    pool[0] = CKPT_START; pool[1] = CKPT_MID; pool[2] = CKPT_DONE; pool[3] = 16'h1234;

    // 0-2 full pass, 3-6 glitch, 7-8 timeout, 9-10 strict skip, 11-12 lenient skip
    tbl.push_back(mk(CKPT_START, 20, 1,  7, 1, 0, 0, 0));
    tbl.push_back(mk(CKPT_MID,   20, 2,  7, 1, 0, 0, 0));
    tbl.push_back(mk(CKPT_DONE,  20, 3,  7, 0, 1, 0, 0));
    tbl.push_back(mk(CKPT_START, 15, 1,  7, 1, 0, 0, 0));
    tbl.push_back(mk(CKPT_MID,    3, 1, -1, 1, 0, 0, 0));
    tbl.push_back(mk(CKPT_START, 15, 1, -1, 1, 0, 0, 0));
    tbl.push_back(mk(CKPT_MID,   10, 2,  7, 1, 0, 0, 0));
    tbl.push_back(mk(CKPT_START, 99, 1,  7, 1, 0, 0, 0));
    tbl.push_back(mk(CKPT_START,  1, 1, -1, 0, 0, 1, 1));
    tbl.push_back(mk(CKPT_START, 15, 1,  7, 1, 0, 0, 0));
    tbl.push_back(mk(CKPT_DONE,  15, 1, -1, 0, 0, 1, 2));
    tbl.push_back(mk(CKPT_START, 15, 1,  7, 1, 0, 0, 0));
    tbl.push_back(mk(CKPT_DONE,  15, 1, -1, 1, 0, 0, 0));

    m_reset();
    exp_codes = {CKPT_DONE, CKPT_MID, CKPT_START};
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fc", fail_code, 0);
    chk("rst_idx", ckpt_idx, 0);
    chk("rst_hit", ckpt_hit, 0);
    chk("rst_sv", stable_val, 0);
    chk("rst_elapsed", elapsed, 0);
    n_tick(2);
    #1 resetb = 1'b1;

    prep(); arm(1'b1); run_rows(0, 2);
    prep(); arm(1'b1); run_rows(3, 6);
    prep(); arm(1'b1); run_rows(7, 8);
    prep(); arm(1'b1); run_rows(9, 10);
    prep(); arm(1'b0); run_rows(11, 12);

    // Value already on the pads requalifies S edges after the arming edge.
    checkbits = CKPT_START;
    n_tick(20);
    arm(1'b1);
    hit_at = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ckpt_hit && hit_at < 0) hit_at = k;
    end
    chk("prepresent_lat", hit_at, S + 1);

    // Asynchronous reset in mid-run.
    prep(); arm(1'b1); run_rows(0, 1);
    #1 resetb = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_pass", pass, 0);
    chk("arst_fail", fail, 0);
    chk("arst_fc", fail_code, 0);
    chk("arst_idx", ckpt_idx, 0);
    chk("arst_hit", ckpt_hit, 0);
    chk("arst_sv", stable_val, 0);
    chk("arst_elapsed", elapsed, 0);
    n_tick(2);
    #2 resetb = 1'b1;
    checkbits = CKPT_START;
    n_tick(12);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_idx", ckpt_idx, 0);
    chk("post_rst_sv", stable_val, CKPT_START);

    // Randomized traffic, including duplicate codes and mid-run re-arms.
    hold_left = 0;
    rst_left  = 0;
    for (int it = 0; it < 3000; it++) begin
      if (hold_left == 0) begin
        if ($urandom_range(0, 4) == 4) checkbits = 16'($urandom);
        else checkbits = pool[$urandom_range(0, 3)];
        hold_left = $urandom_range(1, 12);
      end
      hold_left--;
      if ($urandom_range(0, 59) == 0)
        for (int j = 0; j < N; j++) exp_codes[j*W +: W] = pool[$urandom_range(0, 3)];
      start = 1'b0;
      if ($urandom_range(0, 119) == 0) begin
        strict = 1'($urandom_range(0, 1));
        start  = 1'b1;
      end
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) resetb = 1'b1;
      end else if ($urandom_range(0, 799) == 0) begin
        resetb   = 1'b0;
        rst_left = 2;
      end
      tick();
    end
    start  = 1'b0;
    resetb = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
